// File: rtl/neopixel_driver.sv
// WS2812 single-wire serializer: 24-bit GRB words in over valid/ready, shaped
// pulses out on dout, with a low latch gap closing every frame.
module neopixel_driver #(
  parameter int T0H    = 20,
  parameter int T1H    = 40,
  parameter int TBIT   = 63,
  parameter int TRESET = 15000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] pixel,
  input  logic        pixel_last,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        dout,
  output logic        busy,
  output logic        underrun
);

  localparam int CW = $clog2(TBIT);
  localparam int LW = $clog2(TRESET + 1);

  // Handshake: a word moves on a rising edge where pixel_valid && pixel_ready.
  // pixel_ready never depends on pixel_valid; the producer may hold valid high
  // and must keep pixel/pixel_last stable until the transfer edge.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] lcnt;
  logic [23:0]   shreg;
  logic [4:0]    bidx;
  logic          last;

  logic          bit_end;
  logic          pixel_end;
  logic          xfer;
  logic [CW-1:0] high_len;

  assign bit_end   = (cnt == CW'(TBIT - 1));
  assign pixel_end = (state == SEND) && bit_end && (bidx == 5'd0);
  assign high_len  = shreg[23] ? CW'(T1H) : CW'(T0H);
  assign busy      = (state != IDLE);

  // Ready opens in IDLE, and for the single closing cycle of a non-last pixel
  // so the next word can follow with no gap.
  always_comb begin
    pixel_ready = 1'b0;
    if (!reset) begin
      pixel_ready = (state == IDLE) || (pixel_end && !last);
    end
  end

  assign xfer = pixel_valid && pixel_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      lcnt     <= '0;
      shreg    <= '0;
      bidx     <= '0;
      last     <= 1'b0;
      dout     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      // dout trails cnt by one cycle, so a transfer at edge k rises at k+1.
      dout     <= (state == SEND) && (cnt < high_len);
      case (state)
        IDLE: begin
          if (xfer) begin
            shreg <= pixel;
            last  <= pixel_last;
            bidx  <= 5'd23;
            cnt   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (bit_end) begin
            cnt <= '0;
            if (bidx == 5'd0) begin
              if (xfer) begin
                shreg <= pixel;
                last  <= pixel_last;
                bidx  <= 5'd23;
              end else begin
                // Either the frame ended normally or the producer starved us.
                underrun <= !last;
                lcnt     <= '0;
                state    <= LATCH;
              end
            end else begin
              bidx  <= bidx - 5'd1;
              shreg <= shreg << 1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LATCH: begin
          if (lcnt == LW'(TRESET - 1)) begin
            state <= IDLE;
          end else begin
            lcnt <= lcnt + LW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_driver.sv
// Bench for neopixel_driver: one instance at default timing, one at small
// timing; pulse high-times are scored against an expected queue.
module tb_neopixel_driver;

  localparam int D_T0H = 20, D_T1H = 40, D_TBIT = 63, D_TRESET = 15000;
  localparam int S_T0H = 2,  S_T1H = 4,  S_TBIT = 6,  S_TRESET = 10;

  logic        clock = 1'b0;
  logic        reset_d, reset_s;
  logic [23:0] pixel_d, pixel_s;
  logic        last_d, last_s, valid_d, valid_s;
  logic        ready_d, ready_s, dout_d, dout_s, busy_d, busy_s, ur_d, ur_s;

  neopixel_driver dut_d (
    .clock(clock), .reset(reset_d), .pixel(pixel_d), .pixel_last(last_d),
    .pixel_valid(valid_d), .pixel_ready(ready_d), .dout(dout_d),
    .busy(busy_d), .underrun(ur_d)
  );

  neopixel_driver #(.T0H(S_T0H), .T1H(S_T1H), .TBIT(S_TBIT), .TRESET(S_TRESET)) dut_s (
    .clock(clock), .reset(reset_s), .pixel(pixel_s), .pixel_last(last_s),
    .pixel_valid(valid_s), .pixel_ready(ready_s), .dout(dout_s),
    .busy(busy_s), .underrun(ur_s)
  );

  // clock / reset
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // scoreboard: one expected high-time per bit, pushed at transfer
  logic [15:0] exp_s_q[$];
  logic [15:0] exp_d_q[$];

  int s_xfer_cyc = 0, d_xfer_cyc = 0;
  bit s_pend = 0, d_pend = 0;

  int s_hl = 0, s_prev_rise = -1, s_ones = 0, s_rises = 0, s_ur_total = 0, s_rdy = 0;
  logic s_prev = 1'b0;
  initial forever begin
    @(negedge clock);
    if (reset_s) begin
      s_prev = 1'b0; s_hl = 0; s_prev_rise = -1; s_pend = 0;
    end else begin
      if (ur_s) s_ur_total++;
      if (busy_s && ready_s) s_rdy++;
      if (dout_s && !s_prev) begin
        s_rises++;
        if (s_pend) begin
          check("s_first_rise_latency", cyc - s_xfer_cyc, 1);
          s_pend = 0;
        end
        if (s_prev_rise >= 0) check("s_bit_period", cyc - s_prev_rise, S_TBIT);
        s_prev_rise = cyc;
      end
      if (dout_s) s_hl++;
      if (!dout_s && s_prev) begin
        if (exp_s_q.size() == 0) check("s_unexpected_pulse", s_hl, 0);
        else check("s_high_time", s_hl, int'(exp_s_q.pop_front()));
        if (s_hl == S_T1H) s_ones++;
        s_hl = 0;
      end
      if (!busy_s) s_prev_rise = -1;
      s_prev = dout_s;
    end
  end

  int d_hl = 0, d_prev_rise = -1, d_rises = 0;
  logic d_prev = 1'b0;
  initial forever begin
    @(negedge clock);
    if (reset_d) begin
      d_prev = 1'b0; d_hl = 0; d_prev_rise = -1; d_pend = 0;
    end else begin
      if (dout_d && !d_prev) begin
        d_rises++;
        if (d_pend) begin
          check("d_first_rise_latency", cyc - d_xfer_cyc, 1);
          d_pend = 0;
        end
        if (d_prev_rise >= 0) check("d_bit_period", cyc - d_prev_rise, D_TBIT);
        d_prev_rise = cyc;
      end
      if (dout_d) d_hl++;
      if (!dout_d && d_prev) begin
        if (exp_d_q.size() == 0) check("d_unexpected_pulse", d_hl, 0);
        else check("d_high_time", d_hl, int'(exp_d_q.pop_front()));
        d_hl = 0;
      end
      if (!busy_d) d_prev_rise = -1;
      d_prev = dout_d;
    end
  end

  // driver tasks: present the word, wait for ready, return just after the transfer edge
  task automatic drive_s(input logic [23:0] p, input logic l);
    int n;
    n = 0;
    @(negedge clock);
    pixel_s = p; last_s = l; valid_s = 1'b1;
    #1;
    while (!ready_s && n < 20000) begin
      @(negedge clock); #1; n++;
    end
    if (n >= 20000) timeout("s_ready_wait");
    @(posedge clock); #1;
    s_xfer_cyc = cyc;
    s_pend = 1;
    for (int i = 23; i >= 0; i--) exp_s_q.push_back(p[i] ? 16'(S_T1H) : 16'(S_T0H));
  endtask

  task automatic drive_d(input logic [23:0] p, input logic l);
    int n;
    n = 0;
    @(negedge clock);
    pixel_d = p; last_d = l; valid_d = 1'b1;
    #1;
    while (!ready_d && n < 20000) begin
      @(negedge clock); #1; n++;
    end
    if (n >= 20000) timeout("d_ready_wait");
    @(posedge clock); #1;
    d_xfer_cyc = cyc;
    d_pend = 1;
  endtask

  // wait at negedges until the small instance is idle; returns busy cycles seen
  task automatic wait_idle_s(output int n);
    n = 0;
    while (busy_s && n < 5000) begin
      @(negedge clock); n++;
    end
    if (n >= 5000) timeout("s_idle_wait");
  endtask

  typedef struct {
    logic [23:0] pix;
    logic        last;
    int          ones;
    int          ur;
    int          busy_cyc;
  } vec_t;

  vec_t tbl[5];
  int   d_exp[24];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    int x, x2, n, ur_cnt, ur_at, ones0, rdy0, rises0, ur0, lowviol, exp_ur_total;

    tbl[0] = '{24'h000000, 1'b1, 0,  0, 24*S_TBIT + S_TRESET};
    tbl[1] = '{24'hFFFFFF, 1'b1, 24, 0, 24*S_TBIT + S_TRESET};
    tbl[2] = '{24'hAA0F00, 1'b1, 8,  0, 24*S_TBIT + S_TRESET};
    tbl[3] = '{24'h123456, 1'b0, 9,  1, 24*S_TBIT + S_TRESET};
    tbl[4] = '{24'h800001, 1'b1, 2,  0, 24*S_TBIT + S_TRESET};
    d_exp = '{40,20,40,20,40,20,40,20, 20,20,20,20,40,40,40,40,
              20,20,20,20,20,20,20,20};

    reset_d = 1'b1; reset_s = 1'b1;
    pixel_d = '0; pixel_s = '0; last_d = 0; last_s = 0; valid_d = 0; valid_s = 0;
    repeat (3) @(negedge clock);
    check("rst_dout_s", dout_s, 0);
    check("rst_busy_s", busy_s, 0);
    check("rst_underrun_s", ur_s, 0);
    check("rst_dout_d", dout_d, 0);
    check("rst_busy_d", busy_d, 0);
    reset_d = 1'b0; reset_s = 1'b0;
    #1;
    check("idle_ready_s", ready_s, 1);
    check("idle_ready_d", ready_d, 1);

    // default timing: one last pixel, then the full latch gap
    for (int i = 0; i < 24; i++) exp_d_q.push_back(16'(d_exp[i]));
    drive_d(24'hAA0F00, 1'b1);
    x = d_xfer_cyc;
    @(negedge clock); valid_d = 1'b0;
    n = 0; lowviol = 0;
    while (!ready_d && n < 20000) begin
      if (cyc > x + 24*D_TBIT && dout_d) lowviol++;
      @(negedge clock); n++;
    end
    check("d_cycles_to_ready", n, 24*D_TBIT + D_TRESET);
    check("d_latch_low_violations", lowviol, 0);
    check("d_busy_after_latch", busy_d, 0);
    check("d_pulse_count", d_rises, 24);
    check("d_queue_drained", exp_d_q.size(), 0);

    // table: single frames on the small instance
    exp_ur_total = 0;
    for (int v = 0; v < 5; v++) begin
      ones0 = s_ones;
      drive_s(tbl[v].pix, tbl[v].last);
      x = s_xfer_cyc;
      @(negedge clock); valid_s = 1'b0;
      n = 0; ur_cnt = 0; ur_at = -1;
      while (busy_s && n < 1000) begin
        if (ur_s) begin ur_cnt++; ur_at = cyc - x; end
        @(negedge clock); n++;
      end
      check($sformatf("tbl%0d_busy_cycles", v), n, tbl[v].busy_cyc);
      check($sformatf("tbl%0d_underrun_count", v), ur_cnt, tbl[v].ur);
      if (tbl[v].ur != 0) check($sformatf("tbl%0d_underrun_cycle", v), ur_at, 24*S_TBIT);
      check($sformatf("tbl%0d_ones", v), s_ones - ones0, tbl[v].ones);
      check($sformatf("tbl%0d_ready_idle", v), ready_s, 1);
      check($sformatf("tbl%0d_queue", v), exp_s_q.size(), 0);
      exp_ur_total += tbl[v].ur;
    end

    // three back-to-back pixels with valid held
    rdy0 = s_rdy; rises0 = s_rises; ur0 = s_ur_total;
    drive_s(24'hF0F0F0, 1'b0);
    x = s_xfer_cyc;
    drive_s(24'h0F0F0F, 1'b0);
    x2 = s_xfer_cyc;
    check("b2b_gap_1", x2 - x, 24*S_TBIT);
    drive_s(24'hC3A55A, 1'b1);
    check("b2b_gap_2", s_xfer_cyc - x2, 24*S_TBIT);
    @(negedge clock); valid_s = 1'b0;
    wait_idle_s(n);
    check("b2b_bit_slots", s_rises - rises0, 72);
    check("b2b_ready_pulses", s_rdy - rdy0, 2);
    check("b2b_underrun", s_ur_total - ur0, 0);
    check("b2b_queue", exp_s_q.size(), 0);

    // hold-off: valid stays high across the latch
    drive_s(24'h5A5A5A, 1'b1);
    x = s_xfer_cyc;
    drive_s(24'hA5A5A5, 1'b1);
    check("holdoff_xfer_spacing", s_xfer_cyc - x, 24*S_TBIT + S_TRESET + 1);
    @(negedge clock); valid_s = 1'b0;
    wait_idle_s(n);
    check("holdoff_queue", exp_s_q.size(), 0);

    // asynchronous reset in the middle of bit 12
    drive_s(24'hFFFFFF, 1'b1);
    x = s_xfer_cyc;
    @(negedge clock); valid_s = 1'b0;
    repeat (68) @(negedge clock);
    check("rst12_dout_high", dout_s, 1);
    #2 reset_s = 1'b1;
    exp_s_q.delete();
    #1;
    check("rst12_dout_async", dout_s, 0);
    check("rst12_busy_async", busy_s, 0);
    repeat (2) @(negedge clock);
    #2 reset_s = 1'b0;
    #1;
    check("rst12_ready_after", ready_s, 1);
    drive_s(24'h9C3E71, 1'b1);
    @(negedge clock); valid_s = 1'b0;
    wait_idle_s(n);
    check("rst12_resend_busy", n, 24*S_TBIT + S_TRESET);
    check("rst12_queue", exp_s_q.size(), 0);

    check("total_underruns", s_ur_total, exp_ur_total);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
